irq_csr_unit: RTL and testbench

// - Machine-mode interrupt CSR and trap-request block between the CLINT (timer/software IRQ) / external IRQ line and the CPU core.
// - Holds mstatus.MIE/MPIE, mie, mip and mcause.
// - Prioritises pending & enabled interrupts and raises a held trap request until the core acknowledges at an instruction boundary.
// - Handles trap-entry and mret side effects on mstatus.

---
 rtl/csr_pkg.sv | 38 +++
 rtl/irq_csr_unit_if.sv | 29 ++
 rtl/irq_sync.sv | 23 ++
 rtl/irq_csr_unit.sv | 197 +++++++++++++++++++
 tb/tb_irq_csr_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode interrupt CSR block.
// Holds the CSR addresses, bit positions inside mstatus/mie/mip,
// interrupt cause codes, the trap-request FSM encoding and a helper
// that builds an interrupt mcause value.
package csr_pkg;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS = 12'h300;
  localparam csr_addr_t CSR_MIE     = 12'h304;
  localparam csr_addr_t CSR_MCAUSE  = 12'h342;
  localparam csr_addr_t CSR_MIP     = 12'h344;

  // mstatus fields
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  // mie / mip fields
  localparam int MSI_BIT = 3;
  localparam int MTI_BIT = 7;
  localparam int MEI_BIT = 11;

  // Interrupt exception codes
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_st_e;

  // Interrupt causes carry the MSB set; synchronous exceptions do not.
  function automatic logic [31:0] irq_cause(input logic [3:0] code);
    return {1'b1, 27'd0, code};
  endfunction

endpackage

// File: rtl/irq_csr_unit_if.sv
// Core-side bundle for irq_csr_unit: CSR read/write port plus the
// interrupt trap handshake and exception/mret notifications.
//   master : the CPU core (drives address, write, ack, exc, mret)
//   slave  : irq_csr_unit (returns read data, hit, request, cause)
interface irq_csr_unit_if;
  import csr_pkg::*;

  csr_addr_t   csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdat;
  logic [31:0] csr_rdat;
  logic        csr_hit;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        irq_ack;
  logic        exc_take;
  logic [3:0]  exc_cause;
  logic        mret;

  modport master (
    output csr_addr, csr_we, csr_wdat, irq_ack, exc_take, exc_cause, mret,
    input  csr_rdat, csr_hit, irq_req, irq_cause
  );

  modport slave (
    input  csr_addr, csr_we, csr_wdat, irq_ack, exc_take, exc_cause, mret,
    output csr_rdat, csr_hit, irq_req, irq_cause
  );
endinterface

// File: rtl/irq_sync.sv
// Two-flop synchroniser for an asynchronous level input.
// Ports: i_clk, i_rst (sync, active-high, clears both flops to 0),
//        i_d async input, o_q synchronised output (2 cycle delay).
module irq_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_s1, r_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/irq_csr_unit.sv
// Machine-mode interrupt CSR and trap-request block.
// Holds mstatus.MIE/MPIE, mie, mip and mcause, prioritises pending and
// enabled interrupts (MEI > MSI > MTI) and holds a trap request until the
// core acks it, handling trap-entry and mret side effects on mstatus.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_timer_int         CLINT timer interrupt (level)
//   i_sw_int            CLINT software interrupt (level)
//   i_ext_int           external interrupt (level, optionally synchronised)
//   io_core             core-side CSR bus + trap handshake (slave modport)
module irq_csr_unit
  import csr_pkg::*;
#(
  parameter bit SYNC_EXT  = 1'b0,
  parameter bit RESET_MIE = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_timer_int,
  input  logic           i_sw_int,
  input  logic           i_ext_int,
  irq_csr_unit_if.slave  io_core
);

  logic        w_ext;
  logic        r_mstat_mie, r_mpie;
  logic        r_msie, r_mtie, r_meie;
  logic        r_msip, r_mtip, r_meip;
  logic [31:0] r_mcause;
  logic [31:0] r_cause;
  irq_st_e     r_state, w_state_nxt;

  logic        w_pend_s, w_pend_t, w_pend_e, w_pend_any;
  logic        w_lat_pend;
  logic [3:0]  w_sel_code;
  logic        w_ack, w_exc, w_mret;
  logic        w_wr_mstatus, w_wr_mie, w_wr_mcause;

  generate
    if (SYNC_EXT) begin : g_sync
      irq_sync u_ext_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_ext_int),
        .o_q   (w_ext)
      );
    end else begin : g_nosync
      assign w_ext = i_ext_int;
    end
  endgenerate

  assign w_pend_s   = r_msip & r_msie;
  assign w_pend_t   = r_mtip & r_mtie;
  assign w_pend_e   = r_meip & r_meie;
  assign w_pend_any = w_pend_s | w_pend_t | w_pend_e;

  always_comb begin
    w_sel_code = CODE_MTI;
    if (w_pend_e)      w_sel_code = CODE_MEI;
    else if (w_pend_s) w_sel_code = CODE_MSI;
  end

  // Is the source behind the frozen request still pending?
  always_comb begin
    case (r_cause[3:0])
      CODE_MEI: w_lat_pend = w_pend_e;
      CODE_MSI: w_lat_pend = w_pend_s;
      default:  w_lat_pend = w_pend_t;
    endcase
  end

  // Event priority: ack (only meaningful in REQ) > exception > mret.
  assign w_ack  = io_core.irq_ack & (r_state == ST_REQ);
  assign w_exc  = io_core.exc_take & ~w_ack;
  assign w_mret = io_core.mret & ~w_ack & ~io_core.exc_take;

  assign w_wr_mstatus = io_core.csr_we & (io_core.csr_addr == CSR_MSTATUS);
  assign w_wr_mie     = io_core.csr_we & (io_core.csr_addr == CSR_MIE);
  assign w_wr_mcause  = io_core.csr_we & (io_core.csr_addr == CSR_MCAUSE);

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (r_mstat_mie & w_pend_any & ~io_core.exc_take & ~io_core.mret)
          w_state_nxt = ST_REQ;
      ST_REQ:
        if (w_ack | io_core.exc_take | ~w_lat_pend | ~r_mstat_mie)
          w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs (request is a pure decode of the state flop)
  always_comb begin
    io_core.irq_req   = (r_state == ST_REQ);
    io_core.irq_cause = r_cause;
  end

  // Cause is captured only on IDLE->REQ so it stays frozen while requesting.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cause <= '0;
    else if (r_state == ST_IDLE && w_state_nxt == ST_REQ)
      r_cause <= irq_cause(w_sel_code);
  end

  // mip sampled every cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_msip <= 1'b0;
      r_mtip <= 1'b0;
      r_meip <= 1'b0;
    end else begin
      r_msip <= i_sw_int;
      r_mtip <= i_timer_int;
      r_meip <= w_ext;
    end
  end

  // mie: CSR writes always land
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_msie <= 1'b0;
      r_mtie <= 1'b0;
      r_meie <= 1'b0;
    end else if (w_wr_mie) begin
      r_msie <= io_core.csr_wdat[MSI_BIT];
      r_mtie <= io_core.csr_wdat[MTI_BIT];
      r_meie <= io_core.csr_wdat[MEI_BIT];
    end
  end

  // mstatus: trap/mret effects win over a same-cycle CSR write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mstat_mie <= RESET_MIE;
      r_mpie      <= 1'b0;
    end else if (w_ack | w_exc) begin
      r_mpie      <= r_mstat_mie;
      r_mstat_mie <= 1'b0;
    end else if (w_mret) begin
      r_mstat_mie <= r_mpie;
      r_mpie      <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mstat_mie <= io_core.csr_wdat[MIE_BIT];
      r_mpie      <= io_core.csr_wdat[MPIE_BIT];
    end
  end

  // mcause: trap entry wins over a same-cycle CSR write
  always_ff @(posedge i_clk) begin
    if (i_rst)            r_mcause <= '0;
    else if (w_ack)       r_mcause <= r_cause;
    else if (w_exc)       r_mcause <= {1'b0, 27'd0, io_core.exc_cause};
    else if (w_wr_mcause) r_mcause <= io_core.csr_wdat;
  end

  // CSR read mux, combinational from the address
  always_comb begin
    io_core.csr_rdat = '0;
    io_core.csr_hit  = 1'b0;
    case (io_core.csr_addr)
      CSR_MSTATUS: begin
        io_core.csr_hit            = 1'b1;
        io_core.csr_rdat[MIE_BIT]  = r_mstat_mie;
        io_core.csr_rdat[MPIE_BIT] = r_mpie;
        io_core.csr_rdat[12:11]    = 2'b11;
      end
      CSR_MIE: begin
        io_core.csr_hit           = 1'b1;
        io_core.csr_rdat[MSI_BIT] = r_msie;
        io_core.csr_rdat[MTI_BIT] = r_mtie;
        io_core.csr_rdat[MEI_BIT] = r_meie;
      end
      CSR_MCAUSE: begin
        io_core.csr_hit  = 1'b1;
        io_core.csr_rdat = r_mcause;
      end
      CSR_MIP: begin
        io_core.csr_hit           = 1'b1;
        io_core.csr_rdat[MSI_BIT] = r_msip;
        io_core.csr_rdat[MTI_BIT] = r_mtip;
        io_core.csr_rdat[MEI_BIT] = r_meip;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_csr_unit.sv
// Bench for irq_csr_unit: a table of per-cycle vectors (inputs plus the
// expected outputs one edge later) pushed through a scoreboard queue,
// followed by hand-written sequences for latency, reset mid-request and
// the synchronised external interrupt path (second instance).
module tb_irq_csr_unit;

  typedef struct {
    logic        t, s, e;
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdat;
    logic        ack, exc;
    logic [3:0]  ec;
    logic        mret;
    logic [31:0] rdat;
    logic        hit;
    logic        req;
    logic [31:0] cause;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic timer = 1'b0, sw = 1'b0, ext = 1'b0;
  logic ext_s = 1'b0;

  int checks   = 0;
  int failures = 0;

  vec_t tbl[$];
  vec_t sb[$];

  irq_csr_unit_if bus ();
  irq_csr_unit_if bus_s ();

  irq_csr_unit #(.SYNC_EXT(1'b0), .RESET_MIE(1'b0)) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_timer_int (timer),
    .i_sw_int    (sw),
    .i_ext_int   (ext),
    .io_core     (bus.slave)
  );

  irq_csr_unit #(.SYNC_EXT(1'b1), .RESET_MIE(1'b1)) u_dut_s (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_timer_int (1'b0),
    .i_sw_int    (1'b0),
    .i_ext_int   (ext_s),
    .io_core     (bus_s.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic t, s, e, input logic [11:0] addr, input logic we,
                     input logic [31:0] wdat, input logic ack, exc, input logic [3:0] ec,
                     input logic mret, input logic [31:0] rdat, input logic hit,
                     input logic req, input logic [31:0] cause);
    vec_t v;
    v.t = t; v.s = s; v.e = e; v.addr = addr; v.we = we; v.wdat = wdat;
    v.ack = ack; v.exc = exc; v.ec = ec; v.mret = mret;
    v.rdat = rdat; v.hit = hit; v.req = req; v.cause = cause;
    tbl.push_back(v);
  endtask

  task automatic idle_bus();
    bus.csr_addr = 12'h300; bus.csr_we = 1'b0; bus.csr_wdat = '0;
    bus.irq_ack = 1'b0; bus.exc_take = 1'b0; bus.exc_cause = '0; bus.mret = 1'b0;
  endtask

  initial begin
    vec_t v, e;
    int   lat;

    idle_bus();
    bus_s.csr_addr = 12'h300; bus_s.csr_we = 1'b0; bus_s.csr_wdat = '0;
    bus_s.irq_ack = 1'b0; bus_s.exc_take = 1'b0; bus_s.exc_cause = '0; bus_s.mret = 1'b0;

    //   t  s  e  addr    we wdat          ack exc ec mret rdat         hit req cause
    // reset values
    add(0,0,0,12'h300,0,32'h0,         0,0,0,0, 32'h0000_1800,1,0,32'h0);
    add(0,0,0,12'h304,0,32'h0,         0,0,0,0, 32'h0,        1,0,32'h0);
    add(0,0,0,12'h344,0,32'h0,         0,0,0,0, 32'h0,        1,0,32'h0);
    add(0,0,0,12'h342,0,32'h0,         0,0,0,0, 32'h0,        1,0,32'h0);
    // timer interrupt, ack side effects
    add(0,0,0,12'h304,1,32'hFFFF_FFFF, 0,0,0,0, 32'h0000_0888,1,0,32'h0);
    add(0,0,0,12'h304,1,32'h0000_0080, 0,0,0,0, 32'h0000_0080,1,0,32'h0);
    add(0,0,0,12'h300,1,32'h0000_0008, 0,0,0,0, 32'h0000_1808,1,0,32'h0);
    add(1,0,0,12'h344,0,32'h0,         0,0,0,0, 32'h0000_0080,1,0,32'h0);
    add(1,0,0,12'h300,0,32'h0,         0,0,0,0, 32'h0000_1808,1,1,32'h8000_0007);
    add(1,0,0,12'h342,0,32'h0,         1,0,0,0, 32'h8000_0007,1,0,32'h0);
    add(1,0,0,12'h300,0,32'h0,         0,0,0,0, 32'h0000_1880,1,0,32'h0);
    // priority, frozen cause, withdraw and re-raise
    add(0,0,0,12'h304,1,32'h0000_0888, 0,0,0,0, 32'h0000_0888,1,0,32'h0);
    add(0,1,1,12'h300,1,32'h0000_0008, 0,0,0,0, 32'h0000_1808,1,0,32'h0);
    add(0,1,1,12'h344,0,32'h0,         0,0,0,0, 32'h0000_0808,1,1,32'h8000_000B);
    add(0,1,0,12'h344,0,32'h0,         0,0,0,0, 32'h0000_0008,1,1,32'h8000_000B);
    add(0,1,0,12'h344,0,32'h0,         0,0,0,0, 32'h0000_0008,1,0,32'h0);
    add(0,1,0,12'h344,0,32'h0,         0,0,0,0, 32'h0000_0008,1,1,32'h8000_0003);
    add(1,0,0,12'h342,0,32'h0,         0,0,0,0, 32'h8000_0007,1,1,32'h8000_0003);
    add(1,0,0,12'h342,0,32'h0,         0,0,0,0, 32'h8000_0007,1,0,32'h0);
    add(1,0,0,12'h344,0,32'h0,         0,0,0,0, 32'h0000_0080,1,1,32'h8000_0007);
    // ack + same-cycle mstatus write
    add(1,0,0,12'h300,1,32'h0000_0008, 1,0,0,0, 32'h0000_1880,1,0,32'h0);
    add(1,0,0,12'h342,0,32'h0,         0,0,0,0, 32'h8000_0007,1,0,32'h0);
    // exception in REQ, then mret re-enables
    add(1,0,0,12'h300,1,32'h0000_0008, 0,0,0,0, 32'h0000_1808,1,0,32'h0);
    add(1,0,0,12'h300,0,32'h0,         0,0,0,0, 32'h0000_1808,1,1,32'h8000_0007);
    add(1,0,0,12'h342,0,32'h0,         0,1,2,0, 32'h0000_0002,1,0,32'h0);
    add(1,0,0,12'h300,0,32'h0,         0,0,0,0, 32'h0000_1880,1,0,32'h0);
    add(1,0,0,12'h300,0,32'h0,         0,0,0,1, 32'h0000_1888,1,0,32'h0);
    add(1,0,0,12'h300,0,32'h0,         0,0,0,0, 32'h0000_1888,1,1,32'h8000_0007);
    // mcause write, mie clear withdraws, mip read-only, miss, exc beats mret
    add(0,0,0,12'h342,1,32'h1234_5678, 0,0,0,0, 32'h1234_5678,1,1,32'h8000_0007);
    add(0,0,0,12'h304,1,32'h0,         0,0,0,0, 32'h0,        1,0,32'h0);
    add(0,0,0,12'h344,1,32'hFFFF_FFFF, 0,0,0,0, 32'h0,        1,0,32'h0);
    add(0,0,0,12'h305,0,32'h0,         0,0,0,0, 32'h0,        0,0,32'h0);
    add(0,0,0,12'h342,0,32'h0,         0,1,5,1, 32'h0000_0005,1,0,32'h0);
    add(0,0,0,12'h300,0,32'h0,         0,0,0,0, 32'h0000_1880,1,0,32'h0);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge i_clk);
      v = tbl[i];
      timer = v.t; sw = v.s; ext = v.e;
      bus.csr_addr = v.addr; bus.csr_we = v.we; bus.csr_wdat = v.wdat;
      bus.irq_ack = v.ack; bus.exc_take = v.exc; bus.exc_cause = v.ec; bus.mret = v.mret;
      sb.push_back(v);
      @(posedge i_clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d.rdat", i), bus.csr_rdat, e.rdat);
      chk($sformatf("v%0d.hit", i), {31'd0, bus.csr_hit}, {31'd0, e.hit});
      chk($sformatf("v%0d.req", i), {31'd0, bus.irq_req}, {31'd0, e.req});
      if (e.req) chk($sformatf("v%0d.cause", i), bus.irq_cause, e.cause);
    end

    // Timer latency: driven between edges -> request after the 2nd edge.
    @(negedge i_clk);
    idle_bus(); timer = 1'b0; sw = 1'b0; ext = 1'b0;
    bus.csr_addr = 12'h304; bus.csr_we = 1'b1; bus.csr_wdat = 32'h80;
    @(negedge i_clk);
    bus.csr_addr = 12'h300; bus.csr_wdat = 32'h8;
    @(negedge i_clk);
    bus.csr_we = 1'b0; timer = 1'b1;
    lat = 0;
    do begin
      @(posedge i_clk); #1; lat++;
    end while (!bus.irq_req && lat < 20);
    chk("timer_latency", lat, 2);
    chk("timer_cause", bus.irq_cause, 32'h8000_0007);

    // Reset while requesting
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_req", {31'd0, bus.irq_req}, 32'd0);
    bus.csr_addr = 12'h300; #1 chk("rst_mstatus", bus.csr_rdat, 32'h1800);
    bus.csr_addr = 12'h304; #1 chk("rst_mie", bus.csr_rdat, 32'h0);
    bus.csr_addr = 12'h342; #1 chk("rst_mcause", bus.csr_rdat, 32'h0);
    bus.csr_addr = 12'h344; #1 chk("rst_mip", bus.csr_rdat, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0; timer = 1'b0;

    // Synchronised external path, MIE reset to 1
    bus_s.csr_addr = 12'h300;
    #1 chk("sync_rst_mstatus", bus_s.csr_rdat, 32'h1808);
    @(negedge i_clk);
    bus_s.csr_addr = 12'h304; bus_s.csr_we = 1'b1; bus_s.csr_wdat = 32'h800;
    @(negedge i_clk);
    bus_s.csr_we = 1'b0; ext_s = 1'b1;
    lat = 0;
    do begin
      @(posedge i_clk); #1; lat++;
    end while (!bus_s.irq_req && lat < 20);
    chk("sync_ext_latency", lat, 4);
    chk("sync_ext_cause", bus_s.irq_cause, 32'h8000_000B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
